// File: rtl/down_counter_16bit_timer.sv
// Loadable down-counter/timer with prescaled ticks, one-shot or periodic auto-reload,
// and a one-cycle done pulse at terminal count.
module down_counter_16bit_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             periodic,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic [PW-1:0]    presc;
    logic             tick;
    logic             terminal;

    assign tick     = (state == RUN) && enable && (presc == PRESC_LAST);
    // A load of 0 while running is also treated as terminal on the next tick.
    assign terminal = (count <= WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            presc      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                count      <= load_value;
                reload_reg <= load_value;
                presc      <= '0;
            end else if (stop && state == RUN) begin
                state <= IDLE;
                busy  <= 1'b0;
                presc <= '0;
            end else if (start && state == IDLE) begin
                if (count != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    presc <= '0;
                end else begin
                    done <= 1'b1;
                end
            end else if (state == RUN && enable) begin
                if (tick) begin
                    presc <= '0;
                    if (!terminal) begin
                        count <= count - WIDTH'(1);
                    end else begin
                        done <= 1'b1;
                        // Periodic reload skips showing 0; a zero reload value falls back to one-shot.
                        if (periodic && reload_reg != '0) begin
                            count <= reload_reg;
                        end else begin
                            count <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_down_counter_16bit_timer.sv
// Bench for down_counter_16bit_timer: directed vector table, prescaled sequence,
// and randomized traffic against a cycle-level reference model (PRESCALE 1 and 4).
module tb_down_counter_16bit_timer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, load, start, stop, enable, periodic;
    logic [W-1:0] load_value;
    logic [W-1:0] count1, count4;
    logic         busy1, busy4, done1, done4;

    always #5 clk = ~clk;

    down_counter_16bit_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .stop(stop), .enable(enable), .periodic(periodic),
        .count(count1), .busy(busy1), .done(done1));

    down_counter_16bit_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .stop(stop), .enable(enable), .periodic(periodic),
        .count(count4), .busy(busy4), .done(done4));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: counts enabled running cycles since the last (re)start or load;
    // every PRESCALE-th such cycle is a decrement step.
    typedef struct {
        bit running;
        int value;
        int reload;
        int en_cycles;
        bit done;
    } model_t;

    model_t m1, m4;

    function automatic model_t step(input model_t m, input int p);
        model_t n = m;
        n.done = 1'b0;
        if (reset) begin
            n.running = 1'b0; n.value = 0; n.reload = 0; n.en_cycles = 0;
        end else if (load) begin
            n.value = int'(load_value); n.reload = int'(load_value); n.en_cycles = 0;
        end else if (stop && m.running) begin
            n.running = 1'b0; n.en_cycles = 0;
        end else if (start && !m.running) begin
            if (m.value != 0) begin
                n.running = 1'b1; n.en_cycles = 0;
            end else begin
                n.done = 1'b1;
            end
        end else if (m.running && enable) begin
            n.en_cycles = (m.en_cycles + 1) % p;
            if (n.en_cycles == 0) begin
                if (m.value > 1) begin
                    n.value = m.value - 1;
                end else begin
                    n.done = 1'b1;
                    if (periodic && m.reload != 0) n.value = m.reload;
                    else begin n.value = 0; n.running = 1'b0; end
                end
            end
        end
        return n;
    endfunction

    task automatic drive(input bit r, input bit ld, input int lv, input bit st,
                         input bit sp, input bit en, input bit per);
        reset = r; load = ld; load_value = W'(lv); start = st; stop = sp;
        enable = en; periodic = per;
    endtask

    task automatic cyc();
        @(posedge clk);
        m1 = step(m1, 1);
        m4 = step(m4, 4);
        #1;
    endtask

    task automatic check_models(input string tag);
        chk({tag, " count1"}, int'(count1), m1.value);
        chk({tag, " busy1"},  int'(busy1),  int'(m1.running));
        chk({tag, " done1"},  int'(done1),  int'(m1.done));
        chk({tag, " count4"}, int'(count4), m4.value);
        chk({tag, " busy4"},  int'(busy4),  int'(m4.running));
        chk({tag, " done4"},  int'(done4),  int'(m4.done));
    endtask

    typedef struct {
        bit rst, ld; int lv; bit st, sp, en, per;
        int ec; bit eb, ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit ld, int lv, bit st, bit sp, bit en,
                                bit per, int ec, bit eb, bit ed);
        vec_t v;
        v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.en = en;
        v.per = per; v.ec = ec; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    initial begin
        m1 = '{default: 0};
        m4 = '{default: 0};
        drive(1, 0, 0, 0, 0, 0, 0);

        //          rst ld lv st sp en per  cnt busy done   (PRESCALE=1 expectations)
        // one-shot 3,2,1,0
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 0,  3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0));
        // periodic 3,2,1,3,...
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 1,  3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1,  3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  3, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  3, 1, 1));
        // load while running, stop, load+start, start
        tbl.push_back(mk(0, 1, 4, 0, 0, 1, 0,  4, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,  4, 0, 0));
        tbl.push_back(mk(0, 1, 2, 1, 0, 1, 0,  2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 1));
        // enable pause at 3
        tbl.push_back(mk(0, 1, 5, 0, 0, 1, 0,  5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  5, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  4, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 1));
        // reset mid-run, then start at count 0
        tbl.push_back(mk(0, 1, 9, 0, 0, 1, 0,  9, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  9, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  8, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  7, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0));
        // start while running is ignored
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 0,  3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 1));
        // load 0 while running -> terminal on next tick
        tbl.push_back(mk(0, 1, 5, 0, 0, 1, 0,  5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,  5, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0,  0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 1));

        // reset state
        cyc();
        cyc();
        chk("reset count1", int'(count1), 0);
        chk("reset busy1",  int'(busy1),  0);
        chk("reset done1",  int'(done1),  0);
        chk("reset count4", int'(count4), 0);
        chk("reset busy4",  int'(busy4),  0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp,
                  tbl[i].en, tbl[i].per);
            cyc();
            chk($sformatf("vec%0d count", i), int'(count1), tbl[i].ec);
            chk($sformatf("vec%0d busy", i),  int'(busy1),  int'(tbl[i].eb));
            chk($sformatf("vec%0d done", i),  int'(done1),  int'(tbl[i].ed));
            check_models($sformatf("vec%0d model", i));
        end

        // PRESCALE=4: load 2, start -> 2 for 4 edges, 1 for 4, then 0 with done
        drive(1, 0, 0, 0, 0, 1, 0); cyc();
        drive(0, 1, 2, 0, 0, 1, 0); cyc();
        drive(0, 0, 0, 1, 0, 1, 0); cyc();
        chk("p4 start busy", int'(busy4), 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk($sformatf("p4 edge%0d count", i), int'(count4), (i < 4) ? 2 : ((i < 8) ? 1 : 0));
            chk($sformatf("p4 edge%0d done", i),  int'(done4),  (i == 8) ? 1 : 0);
            chk($sformatf("p4 edge%0d busy", i),  int'(busy4),  (i == 8) ? 0 : 1);
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 6)),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 4) != 0),
                  $urandom_range(0, 1) == 1);
            cyc();
            check_models($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
